// File: rtl/psum_drain.sv
// psum_drain: pops 3x6 psum words from the PE output FIFO and streams them as requantised int8 activations.
// Build option: define PSUM_DRAIN_RELU_EN to clamp negative results to zero before saturation.
//
//  state | meaning
//  IDLE  | waiting for start_i; job parameters latched here
//  FETCH | popping the next word as soon as the FIFO is non-empty
//  LOAD  | popped word arrives on fifo_dout_i and is captured
//  SEND  | emitting elements 0..17 of the captured word
//  DONE  | one-cycle done pulse
module psum_drain #(
    parameter int PSUM_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [CNT_WIDTH-1:0]      num_words_i,
    input  logic [3:0]                shift_i,
    input  logic                      fifo_empty_i,
    input  logic [3*6*PSUM_WIDTH-1:0] fifo_dout_i,
    output logic                      fifo_rd_en_o,
    output logic                      act_valid_o,
    input  logic                      act_ready_i,
    output logic [7:0]                act_o,
    output logic                      act_last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int WORD_W = 3 * 6 * PSUM_WIDTH;
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MAX = PSUM_WIDTH'(127);
    localparam logic signed [PSUM_WIDTH-1:0] SAT_MIN = PSUM_WIDTH'(-128);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;

    state_t                 state, state_nxt;
    logic [WORD_W-1:0]      word_q;
    logic [4:0]             idx_q;
    logic [CNT_WIDTH-1:0]   words_left_q;
    logic [3:0]             shift_q;

    logic                   in_send, hs, last_elem, last_word;
    logic signed [PSUM_WIDTH-1:0] elem, shifted;
    logic [7:0]             act_sat;

    assign in_send   = (state == SEND);
    assign hs        = in_send && act_ready_i;
    assign last_elem = (idx_q == 5'd17);
    assign last_word = (words_left_q == CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = (num_words_i != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (!fifo_empty_i) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                if (hs && last_elem) begin
                    state_nxt = last_word ? DONE : FETCH;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en_o = (state == FETCH) && !fifo_empty_i;
        act_valid_o  = in_send;
        act_last_o   = in_send && last_elem && last_word;
        act_o        = in_send ? act_sat : 8'h00;
        busy_o       = (state != IDLE);
        done_o       = (state == DONE);
    end

    // Job parameters only load in IDLE, so a start_i while busy cannot disturb a running job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q       <= '0;
            idx_q        <= '0;
            words_left_q <= '0;
            shift_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        words_left_q <= num_words_i;
                        shift_q      <= shift_i;
                    end
                end
                LOAD: begin
                    word_q <= fifo_dout_i;
                    idx_q  <= '0;
                end
                SEND: begin
                    if (hs) begin
                        if (last_elem) begin
                            if (!last_word) begin
                                words_left_q <= words_left_q - CNT_WIDTH'(1);
                            end
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Requantisation works purely off registered state, so act_o holds during a stall.
    assign elem    = word_q[int'(idx_q) * PSUM_WIDTH +: PSUM_WIDTH];
    assign shifted = elem >>> shift_q;

    always_comb begin
        act_sat = shifted[7:0];
`ifdef PSUM_DRAIN_RELU_EN
        if (shifted[PSUM_WIDTH-1]) begin
            act_sat = 8'h00;
        end else if (shifted > SAT_MAX) begin
            act_sat = 8'h7F;
        end
`else
        if (shifted > SAT_MAX) begin
            act_sat = 8'h7F;
        end else if (shifted < SAT_MIN) begin
            act_sat = 8'h80;
        end
`endif
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: FIFO model, output monitor and per-scenario checking tasks.
// Expected values follow the PSUM_DRAIN_RELU_EN build option when it is defined.
module tb_psum_drain;

`ifdef PSUM_DRAIN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  num_words = '0;
    logic [3:0]   shift = '0;
    logic         fifo_empty;
    logic [287:0] fifo_dout;
    logic         fifo_rd_en;
    logic         act_valid;
    logic         act_ready = 1'b1;
    logic [7:0]   act_o;
    logic         act_last;
    logic         busy;
    logic         done;

    psum_drain #(.PSUM_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .num_words_i  (num_words),
        .shift_i      (shift),
        .fifo_empty_i (fifo_empty),
        .fifo_dout_i  (fifo_dout),
        .fifo_rd_en_o (fifo_rd_en),
        .act_valid_o  (act_valid),
        .act_ready_i  (act_ready),
        .act_o        (act_o),
        .act_last_o   (act_last),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: read data appears the cycle after a pop; flushed by the shared reset
    logic [287:0] mem [0:7];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= '0;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr % 8];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        act_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    logic [7:0] out_act [$];
    bit         out_last [$];
    int  last_cyc = -1, rise_cyc = -1, pop_cyc = -1, done_cyc = -1;
    int  pop_cnt = 0, done_cnt = 0, valid_cnt = 0, rd_viol = 0, stall_viol = 0;
    bit  prev_valid = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_act = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (act_valid && act_ready) begin
                out_act.push_back(act_o);
                out_last.push_back(act_last);
                if (act_last) last_cyc = cyc;
            end
            if (act_valid && !prev_valid) rise_cyc = cyc;
            if (act_valid) valid_cnt++;
            if (fifo_rd_en) begin pop_cnt++; pop_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (fifo_rd_en && fifo_empty) rd_viol++;
            if (prev_stall && (act_o !== prev_act || act_last !== prev_last)) stall_viol++;
            prev_valid = act_valid;
            prev_stall = act_valid && !act_ready;
            prev_act   = act_o;
            prev_last  = act_last;
        end else begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic push_word(input int base_val, input int step);
        logic [287:0] w;
        int v;
        for (int e = 0; e < 18; e++) begin
            v = base_val + e * step;
            w[e*16 +: 16] = v[15:0];
        end
        mem[wr_ptr % 8] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_raw(input logic [287:0] w);
        mem[wr_ptr % 8] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic drive_start(input int nw, input int sh, output int s);
        @(posedge clk); #1;
        start = 1'b1; num_words = 16'(nw); shift = 4'(sh);
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int maxc, input string nm);
        int k;
        k = 0;
        while (done_cnt == d0 && k < maxc) begin @(posedge clk); k++; end
        n_cmp++;
        if (done_cnt == d0) begin
            n_err++;
            $display("FAIL %s_timeout: done_o not seen within %0d cycles", nm, maxc);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({fifo_rd_en, act_valid, act_last, busy, done, act_o} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {fifo_rd_en, act_valid, act_last, busy, done, act_o});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic;
        int base, d0, s, ex;
        base = out_act.size(); d0 = done_cnt;
        push_word(-5, 1);
        drive_start(1, 0, s);
        wait_done(d0, 100, "t1");
        repeat (3) @(posedge clk);
        n_cmp++;
        if (out_act.size() != base + 18) begin
            n_err++; $display("FAIL t1_count: got %0d want 18", out_act.size() - base);
        end else begin
            for (int e = 0; e < 18; e++) begin
                ex = e - 5;
                if (RELU && ex < 0) ex = 0;
                n_cmp++;
                if (out_act[base+e] !== 8'(ex)) begin
                    n_err++; $display("FAIL t1_act[%0d]: got %0d want %0d", e, $signed(out_act[base+e]), ex);
                end
                n_cmp++;
                if (out_last[base+e] !== (e == 17)) begin
                    n_err++; $display("FAIL t1_last[%0d]: got %0b want %0b", e, out_last[base+e], e == 17);
                end
            end
        end
        n_cmp++;
        if (pop_cyc != s + 1) begin n_err++; $display("FAIL t1_pop_latency: got cycle %0d want %0d", pop_cyc, s + 1); end
        n_cmp++;
        if (rise_cyc != s + 3) begin n_err++; $display("FAIL t1_valid_latency: got cycle %0d want %0d", rise_cyc, s + 3); end
        n_cmp++;
        if (done_cyc != last_cyc + 1) begin n_err++; $display("FAIL t1_done_timing: got cycle %0d want %0d", done_cyc, last_cyc + 1); end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL t1_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_requant;
        logic [287:0] w;
        int base, d0, s;
        int exp_a [3];
        int exp_b [6];
        exp_a = '{127, RELU ? 0 : -128, RELU ? 0 : -2};
        exp_b = '{RELU ? 0 : -4, 127, 127, RELU ? 0 : -128, RELU ? 0 : -128, RELU ? 0 : -1};

        w = '0;
        w[0*16 +: 16] = 16'sd1000;
        w[1*16 +: 16] = -16'sd1000;
        w[2*16 +: 16] = -16'sd7;
        base = out_act.size(); d0 = done_cnt;
        push_raw(w);
        drive_start(1, 2, s);
        wait_done(d0, 100, "t2a");
        n_cmp++;
        if (out_act.size() != base + 18) begin
            n_err++; $display("FAIL t2a_count: got %0d want 18", out_act.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (out_act[base+i] !== 8'(exp_a[i])) begin
                    n_err++; $display("FAIL t2a_act[%0d]: got %0d want %0d", i, $signed(out_act[base+i]), exp_a[i]);
                end
            end
        end

        w = '0;
        w[0*16 +: 16] = -16'sd7;
        w[1*16 +: 16] = 16'sd255;
        w[2*16 +: 16] = 16'sd256;
        w[3*16 +: 16] = -16'sd256;
        w[4*16 +: 16] = -16'sd257;
        w[5*16 +: 16] = -16'sd1;
        base = out_act.size(); d0 = done_cnt;
        push_raw(w);
        drive_start(1, 1, s);
        wait_done(d0, 100, "t2b");
        n_cmp++;
        if (out_act.size() != base + 18) begin
            n_err++; $display("FAIL t2b_count: got %0d want 18", out_act.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (out_act[base+i] !== 8'(exp_b[i])) begin
                    n_err++; $display("FAIL t2b_act[%0d]: got %0d want %0d", i, $signed(out_act[base+i]), exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_multi_word;
        int base, d0, v0, s, k;
        base = out_act.size(); d0 = done_cnt; v0 = rd_viol;
        push_word(1, 1);
        drive_start(3, 0, s);
        for (int w = 1; w < 3; w++) begin
            k = 0;
            while (rd_ptr != wr_ptr && k < 100) begin @(posedge clk); k++; end
            repeat (30) @(posedge clk);
            #1;
            push_word(1 + 18 * w, 1);
        end
        wait_done(d0, 400, "t3");
        repeat (2) @(posedge clk);
        n_cmp++;
        if (rd_viol != v0) begin n_err++; $display("FAIL t3_rd_while_empty: got %0d want 0", rd_viol - v0); end
        n_cmp++;
        if (out_act.size() != base + 54) begin
            n_err++; $display("FAIL t3_count: got %0d want 54", out_act.size() - base);
        end else begin
            for (int i = 0; i < 54; i++) begin
                n_cmp++;
                if (out_act[base+i] !== 8'(i + 1) || out_last[base+i] !== (i == 53)) begin
                    n_err++;
                    $display("FAIL t3_out[%0d]: got act %0d last %0b want act %0d last %0b",
                             i, $signed(out_act[base+i]), out_last[base+i], i + 1, i == 53);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int base, d0, sv0, s;
        base = out_act.size(); d0 = done_cnt; sv0 = stall_viol;
        push_word(10, 1);
        push_word(28, 1);
        rand_ready = 1'b1;
        drive_start(2, 0, s);
        wait_done(d0, 2000, "t4");
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        n_cmp++;
        if (stall_viol != sv0) begin n_err++; $display("FAIL t4_stall_stable: got %0d changes want 0", stall_viol - sv0); end
        n_cmp++;
        if (out_act.size() != base + 36) begin
            n_err++; $display("FAIL t4_count: got %0d want 36", out_act.size() - base);
        end else begin
            for (int i = 0; i < 36; i++) begin
                n_cmp++;
                if (out_act[base+i] !== 8'(i + 10) || out_last[base+i] !== (i == 35)) begin
                    n_err++;
                    $display("FAIL t4_out[%0d]: got act %0d last %0b want act %0d last %0b",
                             i, $signed(out_act[base+i]), out_last[base+i], i + 10, i == 35);
                end
            end
        end
    endtask

    task automatic test_reset_mid_job;
        int base, d0, s, k;
        base = out_act.size();
        push_word(1, 1);
        drive_start(1, 0, s);
        k = 0;
        while (out_act.size() < base + 9 && k < 100) begin @(posedge clk); k++; end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({fifo_rd_en, act_valid, act_last, busy, done, act_o} !== 13'h0) begin
            n_err++;
            $display("FAIL t6_reset_outputs: got %b want 0", {fifo_rd_en, act_valid, act_last, busy, done, act_o});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        base = out_act.size(); d0 = done_cnt;
        push_word(50, 1);
        drive_start(1, 0, s);
        start = 1'b1; num_words = 16'd5; shift = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0, 100, "t6");
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL t6_busy_after: got %b want 0", busy); end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL t6_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++;
        if (out_act.size() != base + 18) begin
            n_err++; $display("FAIL t6_count: got %0d want 18", out_act.size() - base);
        end else begin
            for (int e = 0; e < 18; e++) begin
                n_cmp++;
                if (out_act[base+e] !== 8'(e + 50)) begin
                    n_err++; $display("FAIL t6_act[%0d]: got %0d want %0d", e, $signed(out_act[base+e]), e + 50);
                end
            end
        end
    endtask

    task automatic test_zero_words;
        int d0, p0, v0, s;
        d0 = done_cnt; p0 = pop_cnt; v0 = valid_cnt;
        push_word(3, 1);
        drive_start(0, 0, s);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL t5_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++;
        if (done_cyc != s + 1) begin n_err++; $display("FAIL t5_done_timing: got cycle %0d want %0d", done_cyc, s + 1); end
        n_cmp++;
        if (pop_cnt != p0) begin n_err++; $display("FAIL t5_no_pop: got %0d pops want 0", pop_cnt - p0); end
        n_cmp++;
        if (valid_cnt != v0) begin n_err++; $display("FAIL t5_no_valid: got %0d valid cycles want 0", valid_cnt - v0); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL t5_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_requant();
        test_multi_word();
        test_backpressure();
        test_reset_mid_job();
        test_zero_words();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
